// File: rtl/mips_cpu_regfile_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
package mips_cpu_regfile_pkg;

    // Architectural register numbers with a fixed role
    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_RA   = 31;

    // Native MIPS word width
    localparam int DEFAULT_DATA_W = 32;

    // Architectural 5-bit register specifier
    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/mips_cpu_regfile_rdport.sv
// One combinational read port of the register file.
// Handles the hard-wired zero register, optional same-cycle write forwarding
// and the pending-load flag for the addressed register.
module mips_cpu_regfile_rdport
    import mips_cpu_regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   busy,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic [DATA_W-1:0]      wr0_data,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic [DATA_W-1:0]      wr1_data,
    output logic [DATA_W-1:0]      data,
    output logic                   pending
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = (addr == ADDR_W'(REG_ZERO));
    assign hit0    = wr0_en && (wr0_addr == addr);
    assign hit1    = wr1_en && (wr1_addr == addr);

    // Select stored value, forwarded write data (load port has priority), or zero
    always_comb begin
        data    = regs[addr];
        pending = busy[addr];
        if (BYPASS != 0) begin
            if (hit0) begin
                data = wr0_data;
            end
            if (hit1) begin
                // The returning load both supplies the data and retires the pending flag
                data    = wr1_data;
                pending = 1'b0;
            end
        end
        if (is_zero) begin
            data    = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-port MIPS GPR file with HI/LO and a busy scoreboard for outstanding loads.
// Two write ports (wr0 = ALU writeback, wr1 = load writeback), NUM_RD
// combinational read ports, plus a dedicated observation port for $v0.
module mips_cpu_regfile_mp
    import mips_cpu_regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       busy_set_en,
    input  logic [ADDR_W-1:0]          busy_set_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       hilo_we,
    input  logic [DATA_W-1:0]          hi_in,
    input  logic [DATA_W-1:0]          lo_in,
    output logic [DATA_W-1:0]          hi_out,
    output logic [DATA_W-1:0]          lo_out,
    output logic [DATA_W-1:0]          register_v0
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] V0_A    = ADDR_W'(REG_V0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              v0_pending;

    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    // Writes and busy sets aimed at $zero are discarded
    assign wr0_ok = wr0_en      && (wr0_addr      != ZERO_A);
    assign wr1_ok = wr1_en      && (wr1_addr      != ZERO_A);
    assign set_ok = busy_set_en && (busy_set_addr != ZERO_A);

    // GPR storage; wr1 is issued last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                regs[wr1_addr] <= wr1_data;
            end
        end
    end

    // Load scoreboard; a fresh issue outranks a completing load to the same register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wr1_ok) begin
                busy[wr1_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy[busy_set_addr] <= 1'b1;
            end
        end
    end

    // HI/LO pair updated together by multiply/divide results
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we) begin
            hi <= hi_in;
            lo <= lo_in;
        end
    end

    assign hi_out = hi;
    assign lo_out = lo;

    // One read port per packed address slot
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        mips_cpu_regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .addr     (rd_addr[g*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .busy     (busy),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .data     (rd_data[g*DATA_W +: DATA_W]),
            .pending  (rd_busy[g])
        );
    end

    // $v0 observation port behaves exactly like a read port fixed on register 2
    mips_cpu_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_v0 (
        .addr     (V0_A),
        .regs     (regs),
        .busy     (busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .data     (register_v0),
        .pending  (v0_pending)
    );

    // The $v0 pending flag has no consumer; fold it away without a dangling net
    logic unused_ok;
    assign unused_ok = &{1'b0, v0_pending};

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Bench for mips_cpu_regfile_mp: a 4-read-port bypassing instance and a
// 1-read-port non-bypassing instance share the write/control inputs.
// Stimulus pushes expectations tagged with a cycle number; a negedge
// monitor pops and compares them against the DUT outputs.
module tb_mips_cpu_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr0_en, wr1_en, busy_set_en, hilo_we;
    logic [AW-1:0]     wr0_addr, wr1_addr, busy_set_addr;
    logic [DW-1:0]     wr0_data, wr1_data, hi_in, lo_in;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [DW-1:0]     hi_out, lo_out, register_v0;

    logic [AW-1:0]     nb_rd_addr;
    logic [DW-1:0]     nb_rd_data;
    logic [0:0]        nb_rd_busy;
    logic [DW-1:0]     nb_hi_out, nb_lo_out, nb_v0;

    always #5 clk = ~clk;

    mips_cpu_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(hi_out), .lo_out(lo_out), .register_v0(register_v0)
    );

    mips_cpu_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(nb_hi_out), .lo_out(nb_lo_out), .register_v0(nb_v0)
    );

    // Output selectors for expectations
    localparam int S_DATA = 0, S_BUSY = 1, S_HI = 2, S_LO = 3, S_V0 = 4,
                   S_NBDATA = 5, S_NBBUSY = 6, S_NBV0 = 7;

    typedef struct {
        int          cyc;
        int          sel;
        int          port;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel, input int port);
        case (sel)
            S_DATA:   return rd_data[port*DW +: DW];
            S_BUSY:   return {31'b0, rd_busy[port]};
            S_HI:     return hi_out;
            S_LO:     return lo_out;
            S_V0:     return register_v0;
            S_NBDATA: return nb_rd_data;
            S_NBBUSY: return {31'b0, nb_rd_busy[0]};
            S_NBV0:   return nb_v0;
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compare every expectation that is due in the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.sel, e.port);
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_miss++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", e.nm, e.cyc, act, e.val);
            end
        end
    end

    task automatic expect_v(input int sel, input int port, input logic [31:0] val, input string nm);
        exp_t x;
        x.cyc = cyc; x.sel = sel; x.port = port; x.val = val; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic set_rd(input int p, input int a);
        logic [AW-1:0] a5;
        a5 = a[AW-1:0];
        rd_addr[p*AW +: AW] = a5;
    endtask

    // Advance to the next cycle and return all control inputs to idle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr0_en = 1'b0; wr1_en = 1'b0; busy_set_en = 1'b0; hilo_we = 1'b0;
        rd_addr = '0; nb_rd_addr = '0;
    endtask

    initial begin
        reset = 1'b1;
        wr0_en = 1'b0; wr1_en = 1'b0; busy_set_en = 1'b0; hilo_we = 1'b0;
        wr0_addr = '0; wr1_addr = '0; busy_set_addr = '0;
        wr0_data = '0; wr1_data = '0; hi_in = '0; lo_in = '0;
        rd_addr = '0; nb_rd_addr = '0;

        // Reset pulse, then every register reads zero and idle
        next_cycle();
        for (int r = 0; r < 32; r += 4) begin
            for (int p = 0; p < NR; p++) begin
                set_rd(p, r + p);
                expect_v(S_DATA, p, 32'h0, $sformatf("reset_data_r%0d", r + p));
                expect_v(S_BUSY, p, 32'h0, $sformatf("reset_busy_r%0d", r + p));
            end
            if (r == 0) begin
                expect_v(S_HI, 0, 32'h0, "reset_hi");
                expect_v(S_LO, 0, 32'h0, "reset_lo");
                expect_v(S_V0, 0, 32'h0, "reset_v0");
            end
            next_cycle();
        end

        // $zero ignores writes
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF;
        set_rd(0, 0); nb_rd_addr = 5'd0;
        expect_v(S_DATA, 0, 32'h0, "r0_same_cycle");
        expect_v(S_NBDATA, 0, 32'h0, "r0_same_cycle_nb");
        next_cycle();
        set_rd(0, 0); nb_rd_addr = 5'd0;
        expect_v(S_DATA, 0, 32'h0, "r0_later");
        expect_v(S_NBDATA, 0, 32'h0, "r0_later_nb");
        next_cycle();

        // Bypass vs stored-only read of a fresh ALU write
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234;
        set_rd(0, 5); nb_rd_addr = 5'd5;
        expect_v(S_DATA, 0, 32'h1234, "bypass_wr0");
        expect_v(S_NBDATA, 0, 32'h0, "nobypass_wr0_same");
        next_cycle();
        set_rd(0, 5); nb_rd_addr = 5'd5;
        expect_v(S_DATA, 0, 32'h1234, "wr0_after");
        expect_v(S_NBDATA, 0, 32'h1234, "nobypass_wr0_after");
        next_cycle();

        // Both write ports to one register: load port wins
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555;
        set_rd(0, 7); nb_rd_addr = 5'd7;
        expect_v(S_DATA, 0, 32'h5555, "collide_bypass");
        expect_v(S_NBDATA, 0, 32'h0, "collide_nb_same");
        next_cycle();
        set_rd(0, 7); nb_rd_addr = 5'd7;
        expect_v(S_DATA, 0, 32'h5555, "collide_after");
        expect_v(S_NBDATA, 0, 32'h5555, "collide_nb_after");
        next_cycle();

        // Scoreboard: set, observe, clear by load return
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        set_rd(0, 9);
        expect_v(S_BUSY, 0, 32'h0, "busy_before_edge");
        next_cycle();
        set_rd(0, 9); set_rd(1, 9); nb_rd_addr = 5'd9;
        expect_v(S_BUSY, 0, 32'h1, "busy_set");
        expect_v(S_BUSY, 1, 32'h1, "busy_set_p1");
        expect_v(S_NBBUSY, 0, 32'h1, "busy_set_nb");
        next_cycle();
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h77;
        set_rd(0, 9); nb_rd_addr = 5'd9;
        expect_v(S_BUSY, 0, 32'h0, "busy_masked_by_wr1");
        expect_v(S_DATA, 0, 32'h77, "load_bypass");
        expect_v(S_NBBUSY, 0, 32'h1, "busy_nb_unmasked");
        next_cycle();
        set_rd(0, 9); nb_rd_addr = 5'd9;
        expect_v(S_BUSY, 0, 32'h0, "busy_cleared");
        expect_v(S_DATA, 0, 32'h77, "load_data");
        expect_v(S_NBBUSY, 0, 32'h0, "busy_cleared_nb");
        next_cycle();

        // Same-cycle set and clear: set wins
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h88;
        set_rd(0, 9);
        expect_v(S_DATA, 0, 32'h88, "setclr_bypass");
        next_cycle();
        set_rd(0, 9); nb_rd_addr = 5'd9;
        expect_v(S_BUSY, 0, 32'h1, "setclr_set_wins");
        expect_v(S_NBBUSY, 0, 32'h1, "setclr_set_wins_nb");
        expect_v(S_DATA, 0, 32'h88, "setclr_data");
        next_cycle();
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        next_cycle();
        set_rd(0, 9);
        expect_v(S_BUSY, 0, 32'h0, "setclr_then_clear");
        next_cycle();

        // wr0 never clears a busy bit
        busy_set_en = 1'b1; busy_set_addr = 5'd10;
        next_cycle();
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h10;
        next_cycle();
        set_rd(2, 10);
        expect_v(S_BUSY, 2, 32'h1, "wr0_keeps_busy");
        expect_v(S_DATA, 2, 32'h10, "wr0_data_r10");
        next_cycle();

        // $v0 observation port
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hCAFE;
        expect_v(S_V0, 0, 32'hCAFE, "v0_bypass");
        expect_v(S_NBV0, 0, 32'h0, "v0_nb_same");
        next_cycle();
        expect_v(S_V0, 0, 32'hCAFE, "v0_after");
        expect_v(S_NBV0, 0, 32'hCAFE, "v0_nb_after");
        next_cycle();

        // Reset mid-operation
        busy_set_en = 1'b1; busy_set_addr = 5'd3;
        hilo_we = 1'b1; hi_in = 32'h1; lo_in = 32'h2;
        expect_v(S_HI, 0, 32'h0, "hi_no_bypass");
        next_cycle();
        set_rd(0, 3);
        expect_v(S_BUSY, 0, 32'h1, "busy3_set");
        expect_v(S_HI, 0, 32'h1, "hi_written");
        expect_v(S_LO, 0, 32'h2, "lo_written");
        next_cycle();
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h4444;
        busy_set_en = 1'b1; busy_set_addr = 5'd6;
        hilo_we = 1'b1; hi_in = 32'hAB; lo_in = 32'hCD;
        next_cycle();
        set_rd(0, 3); set_rd(1, 4); set_rd(2, 6); set_rd(3, 5);
        expect_v(S_BUSY, 0, 32'h0, "rst_busy3");
        expect_v(S_DATA, 1, 32'h0, "rst_r4_write_dropped");
        expect_v(S_BUSY, 2, 32'h0, "rst_busy6_set_dropped");
        expect_v(S_DATA, 3, 32'h0, "rst_r5_cleared");
        expect_v(S_HI, 0, 32'h0, "rst_hi");
        expect_v(S_LO, 0, 32'h0, "rst_lo");
        expect_v(S_V0, 0, 32'h0, "rst_v0");
        next_cycle();
        // A load that returns after reset still writes its register
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h33;
        next_cycle();
        set_rd(0, 3);
        expect_v(S_DATA, 0, 32'h33, "late_load_data");
        expect_v(S_BUSY, 0, 32'h0, "late_load_busy");
        next_cycle();

        // Four ports read four distinct registers at once
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h22;
        next_cycle();
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44;
        next_cycle();
        for (int p = 0; p < NR; p++) begin
            logic [31:0] v;
            v = 32'h11 * (p + 1);
            set_rd(p, p + 1);
            expect_v(S_DATA, p, v, $sformatf("multiport_p%0d", p));
        end
        expect_v(S_V0, 0, 32'h22, "multiport_v0");
        next_cycle();
        next_cycle();

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
